arp_table_reg_ctrl: RTL and testbench

// Register-side initiator for the ARP next-hop table read/write ports of the IP/CCCP ARP lookup block.

---
 rtl/arp_table_reg_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_arp_table_reg_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_table_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arp_table_reg_ctrl
// Description : Register-side initiator for the ARP next-hop table. It accepts
//               one software command at a time and turns it into a table read
//               or into a write to both CAM tables (LPM and CCCP). Every access
//               is bounded by a timeout. One status response is returned per
//               command.
// Ports       : clk, reset               - clock, synchronous active-high reset
//               cmd_*                    - command channel (valid/ready)
//               rsp_*                    - response channel (valid/ready)
//               arp_rd_*                 - table read port (req level, ack pulse)
//               arp_wr_*                 - shared write port (req level, two acks)
// Revision    : 1.0 - initial release
// ============================================================================
module arp_table_reg_ctrl #(
  parameter int LUT_DEPTH      = 32,
  parameter int LUT_DEPTH_BITS = 5,
  parameter int TIMEOUT        = 255,
  parameter int TO_BITS        = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_wr,
  input  logic [LUT_DEPTH_BITS-1:0] cmd_addr,
  input  logic [47:0]               cmd_mac,
  input  logic [31:0]               cmd_ip,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [47:0]               rsp_mac,
  output logic [31:0]               rsp_ip,
  output logic [1:0]                rsp_err,
  output logic [LUT_DEPTH_BITS-1:0] arp_rd_addr,
  output logic                      arp_rd_req,
  input  logic [47:0]               arp_rd_mac,
  input  logic [31:0]               arp_rd_ip,
  input  logic                      arp_rd_ack,
  output logic [LUT_DEPTH_BITS-1:0] arp_wr_addr,
  output logic                      arp_wr_req,
  output logic [47:0]               arp_wr_mac,
  output logic [31:0]               arp_wr_ip,
  input  logic                      arp_wr_ack_lpm,
  input  logic                      arp_wr_ack_cccp
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;

  // The address is compared one bit wider so that a depth equal to
  // 2**LUT_DEPTH_BITS is representable.
  localparam logic [LUT_DEPTH_BITS:0] DEPTH_EXT = (LUT_DEPTH_BITS + 1)'(LUT_DEPTH);

  // The counter holds the number of wait cycles already completed, so the
  // TIMEOUT-th wait cycle is the one where it reads TIMEOUT-1. The request is
  // therefore high for exactly TIMEOUT cycles when no completion arrives.
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);
  localparam logic [TO_BITS-1:0] TO_MAX  = {TO_BITS{1'b1}};

  state_t                    state_q,     state_d;
  logic [LUT_DEPTH_BITS-1:0] addr_q,      addr_d;
  logic [47:0]               mac_q,       mac_d;
  logic [31:0]               ip_q,        ip_d;
  logic                      lpm_done_q,  lpm_done_d;
  logic                      cccp_done_q, cccp_done_d;
  logic [TO_BITS-1:0]        cnt_q,       cnt_d;
  logic [47:0]               rsp_mac_q,   rsp_mac_d;
  logic [31:0]               rsp_ip_q,    rsp_ip_d;
  logic [1:0]                rsp_err_q,   rsp_err_d;

  logic addr_oor;
  logic lpm_now;
  logic cccp_now;
  logic to_hit;
  logic [TO_BITS-1:0] cnt_inc;

  always_comb begin
    addr_oor = ({1'b0, cmd_addr} >= DEPTH_EXT);
    // A flag raised by an ack in this very cycle already counts.
    lpm_now  = lpm_done_q  | arp_wr_ack_lpm;
    cccp_now = cccp_done_q | arp_wr_ack_cccp;
    to_hit   = (cnt_q == TO_LAST);
    cnt_inc  = (cnt_q == TO_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mac_d       = mac_q;
    ip_d        = ip_q;
    lpm_done_d  = lpm_done_q;
    cccp_done_d = cccp_done_q;
    cnt_d       = cnt_q;
    rsp_mac_d   = rsp_mac_q;
    rsp_ip_d    = rsp_ip_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          mac_d       = cmd_mac;
          ip_d        = cmd_ip;
          lpm_done_d  = 1'b0;
          cccp_done_d = 1'b0;
          cnt_d       = '0;
          rsp_mac_d   = '0;
          rsp_ip_d    = '0;
          if (addr_oor) begin
            rsp_err_d = ERR_RANGE;
            state_d   = ST_RESP;
          end else begin
            rsp_err_d = ERR_OK;
            state_d   = cmd_wr ? ST_WR_WAIT : ST_RD_WAIT;
          end
        end
      end

      ST_RD_WAIT: begin
        // Ack is checked before the timeout so a last-cycle ack still succeeds.
        if (arp_rd_ack) begin
          rsp_mac_d = arp_rd_mac;
          rsp_ip_d  = arp_rd_ip;
          rsp_err_d = ERR_OK;
          state_d   = ST_RESP;
        end else if (to_hit) begin
          rsp_err_d = ERR_TIMEOUT;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_WR_WAIT: begin
        lpm_done_d  = lpm_now;
        cccp_done_d = cccp_now;
        if (lpm_now && cccp_now) begin
          rsp_err_d = ERR_OK;
          state_d   = ST_RESP;
        end else if (to_hit) begin
          rsp_err_d = ERR_TIMEOUT;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      mac_q       <= '0;
      ip_q        <= '0;
      lpm_done_q  <= 1'b0;
      cccp_done_q <= 1'b0;
      cnt_q       <= '0;
      rsp_mac_q   <= '0;
      rsp_ip_q    <= '0;
      rsp_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mac_q       <= mac_d;
      ip_q        <= ip_d;
      lpm_done_q  <= lpm_done_d;
      cccp_done_q <= cccp_done_d;
      cnt_q       <= cnt_d;
      rsp_mac_q   <= rsp_mac_d;
      rsp_ip_q    <= rsp_ip_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // All outputs come straight from state or latched registers, so requests
  // and response fields are glitch-free and stable for the whole phase.
  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_mac     = rsp_mac_q;
  assign rsp_ip      = rsp_ip_q;
  assign rsp_err     = rsp_err_q;
  assign arp_rd_addr = addr_q;
  assign arp_rd_req  = (state_q == ST_RD_WAIT);
  assign arp_wr_addr = addr_q;
  assign arp_wr_req  = (state_q == ST_WR_WAIT);
  assign arp_wr_mac  = mac_q;
  assign arp_wr_ip   = ip_q;

endmodule
`default_nettype wire

// File: tb/tb_arp_table_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_arp_table_reg_ctrl
// Description : Self-checking bench for arp_table_reg_ctrl. Each command is
//               reduced to a timing plan (request length, error code, data)
//               from the access rules; a compare process checks every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arp_table_reg_ctrl;

  localparam int DEPTH = 24;
  localparam int AW    = 5;
  localparam int TO    = 255;
  localparam int TOB   = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [47:0]   cmd_mac;
  logic [31:0]   cmd_ip;
  logic          rsp_valid, rsp_ready;
  logic [47:0]   rsp_mac;
  logic [31:0]   rsp_ip;
  logic [1:0]    rsp_err;
  logic [AW-1:0] arp_rd_addr, arp_wr_addr;
  logic          arp_rd_req, arp_rd_ack, arp_wr_req;
  logic [47:0]   arp_rd_mac, arp_wr_mac;
  logic [31:0]   arp_rd_ip, arp_wr_ip;
  logic          arp_wr_ack_lpm, arp_wr_ack_cccp;

  arp_table_reg_ctrl #(
    .LUT_DEPTH(DEPTH), .LUT_DEPTH_BITS(AW), .TIMEOUT(TO), .TO_BITS(TOB)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_mac(cmd_mac), .cmd_ip(cmd_ip),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mac(rsp_mac),
    .rsp_ip(rsp_ip), .rsp_err(rsp_err),
    .arp_rd_addr(arp_rd_addr), .arp_rd_req(arp_rd_req), .arp_rd_mac(arp_rd_mac),
    .arp_rd_ip(arp_rd_ip), .arp_rd_ack(arp_rd_ack),
    .arp_wr_addr(arp_wr_addr), .arp_wr_req(arp_wr_req), .arp_wr_mac(arp_wr_mac),
    .arp_wr_ip(arp_wr_ip), .arp_wr_ack_lpm(arp_wr_ack_lpm),
    .arp_wr_ack_cccp(arp_wr_ack_cccp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  // expected outputs for the current cycle
  logic          chk_en;
  logic          exp_ready, exp_rd_req, exp_wr_req, exp_rsp_valid;
  logic [47:0]   exp_mac, exp_wmac;
  logic [31:0]   exp_ip, exp_wip;
  logic [1:0]    exp_err;
  logic [AW-1:0] exp_addr;

  // observations used by the literal checks
  int   req_hi_cnt    = 0;
  int   rsp_first_cyc = 0;
  int   accept_cyc    = 0;
  logic rsp_prev      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready",  64'(cmd_ready),  64'(exp_ready));
      check("arp_rd_req", 64'(arp_rd_req), 64'(exp_rd_req));
      check("arp_wr_req", 64'(arp_wr_req), 64'(exp_wr_req));
      check("rsp_valid",  64'(rsp_valid),  64'(exp_rsp_valid));
      if (exp_rsp_valid) begin
        check("rsp_mac", 64'(rsp_mac), 64'(exp_mac));
        check("rsp_ip",  64'(rsp_ip),  64'(exp_ip));
        check("rsp_err", 64'(rsp_err), 64'(exp_err));
      end
      if (exp_rd_req) check("arp_rd_addr", 64'(arp_rd_addr), 64'(exp_addr));
      if (exp_wr_req) begin
        check("arp_wr_addr", 64'(arp_wr_addr), 64'(exp_addr));
        check("arp_wr_mac",  64'(arp_wr_mac),  64'(exp_wmac));
        check("arp_wr_ip",   64'(arp_wr_ip),   64'(exp_wip));
      end
    end
    if (arp_rd_req || arp_wr_req) req_hi_cnt++;
    if (rsp_valid && !rsp_prev) rsp_first_cyc = cyc;
    rsp_prev = rsp_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_ready     = 1'b1;
    exp_rd_req    = 1'b0;
    exp_wr_req    = 1'b0;
    exp_rsp_valid = 1'b0;
  endtask

  task automatic stale_acks();
    arp_rd_ack      = ($urandom % 4) == 0;
    arp_wr_ack_lpm  = ($urandom % 4) == 0;
    arp_wr_ack_cccp = ($urandom % 4) == 0;
    arp_rd_mac      = 48'({$urandom, $urandom});
    arp_rd_ip       = $urandom;
  endtask

  task automatic clear_acks();
    arp_rd_ack      = 1'b0;
    arp_wr_ack_lpm  = 1'b0;
    arp_wr_ack_cccp = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      cmd_valid = 1'b0;
      rsp_ready = 1'($urandom % 2);
      stale_acks();
      set_idle_exp();
      step();
    end
    clear_acks();
  endtask

  // One command. Offsets count wait cycles from the first request cycle
  // (0 = ack in the first request cycle, -1 = never). l2 is a repeated lpm
  // ack. rst_at asserts reset in that wait cycle.
  task automatic run_cmd(input bit wr, input int addr, input logic [47:0] mac,
                         input logic [31:0] ip, input int a_off,
                         input logic [47:0] rmac, input logic [31:0] rip,
                         input int l1, input int l2, input int c_off,
                         input int hold, input int rst_at);
    int         len, done;
    logic [1:0] err;
    bit         oor, was_reset;
    oor       = (addr >= DEPTH);
    was_reset = 1'b0;
    if (oor) begin
      len = 0;
      err = 2'd2;
    end else begin
      if (!wr)                      done = a_off;
      else if (l1 < 0 || c_off < 0) done = -1;
      else                          done = (l1 > c_off) ? l1 : c_off;
      if (done >= 0 && done < TO) begin len = done + 1; err = 2'd0; end
      else                        begin len = TO;       err = 2'd1; end
    end

    // acceptance cycle; stale acks here must not leak into the new command
    req_hi_cnt = 0;
    stale_acks();
    cmd_valid  = 1'b1;
    cmd_wr     = wr;
    cmd_addr   = AW'(addr);
    cmd_mac    = mac;
    cmd_ip     = ip;
    rsp_ready  = 1'($urandom % 2);
    set_idle_exp();
    accept_cyc = cyc;
    step();

    // scramble the command bus to prove the request uses latched values
    cmd_valid = 1'b0;
    cmd_wr    = 1'($urandom % 2);
    cmd_addr  = AW'($urandom);
    cmd_mac   = 48'({$urandom, $urandom});
    cmd_ip    = $urandom;
    exp_addr  = AW'(addr);
    exp_wmac  = mac;
    exp_wip   = ip;

    for (int w = 0; w < len && !was_reset; w++) begin
      exp_ready       = 1'b0;
      exp_rd_req      = !wr;
      exp_wr_req      = wr;
      exp_rsp_valid   = 1'b0;
      rsp_ready       = 1'($urandom % 2);
      arp_rd_ack      = !wr && (w == a_off);
      arp_rd_mac      = arp_rd_ack ? rmac : 48'({$urandom, $urandom});
      arp_rd_ip       = arp_rd_ack ? rip  : $urandom;
      arp_wr_ack_lpm  = wr && (w == l1 || w == l2);
      arp_wr_ack_cccp = wr && (w == c_off);
      reset           = (w == rst_at);
      step();
      if (reset) begin
        reset     = 1'b0;
        was_reset = 1'b1;
      end
    end

    if (!was_reset) begin
      exp_mac = (!wr && !oor && err == 2'd0) ? rmac : 48'd0;
      exp_ip  = (!wr && !oor && err == 2'd0) ? rip  : 32'd0;
      exp_err = err;
      for (int h = 0; h <= hold; h++) begin
        exp_ready     = 1'b0;
        exp_rd_req    = 1'b0;
        exp_wr_req    = 1'b0;
        exp_rsp_valid = 1'b1;
        rsp_ready     = (h == hold);
        stale_acks();
        step();
      end
    end
    rsp_ready = 1'b0;
    clear_acks();
    set_idle_exp();
  endtask

  bit          r_wr;
  int          r_addr, r_a, r_l1, r_l2, r_c, r_sel;
  logic [47:0] r_mac, r_rmac;
  logic [31:0] r_ip, r_rip;

  initial begin
    reset     = 1'b1;
    chk_en    = 1'b0;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_mac   = '0;
    cmd_ip    = '0;
    rsp_ready = 1'b0;
    arp_rd_mac = '0;
    arp_rd_ip  = '0;
    clear_acks();
    set_idle_exp();
    step();
    step();
    chk_en = 1'b1;
    step();

    // reset state
    check("rst_cmd_ready",   64'(cmd_ready),   64'd1);
    check("rst_rsp_valid",   64'(rsp_valid),   64'd0);
    check("rst_rsp_mac",     64'(rsp_mac),     64'd0);
    check("rst_rsp_ip",      64'(rsp_ip),      64'd0);
    check("rst_rsp_err",     64'(rsp_err),     64'd0);
    check("rst_rd_req",      64'(arp_rd_req),  64'd0);
    check("rst_wr_req",      64'(arp_wr_req),  64'd0);
    check("rst_rd_addr",     64'(arp_rd_addr), 64'd0);
    check("rst_wr_addr",     64'(arp_wr_addr), 64'd0);
    check("rst_wr_mac",      64'(arp_wr_mac),  64'd0);
    check("rst_wr_ip",       64'(arp_wr_ip),   64'd0);
    reset = 1'b0;
    idle(2);

    // read addr 3, ack two cycles after the request rises
    run_cmd(0, 3, 48'h0, 32'h0, 2, 48'h0011223344ff, 32'h0a000001, -1, -1, -1, 1, -1);
    check("rd_latency",  64'(rsp_first_cyc - accept_cyc), 64'd4);
    check("rd_req_len",  64'(req_hi_cnt), 64'd3);
    idle(1);

    // write addr 7: lpm ack at wait cycle 2, cccp at 5
    run_cmd(1, 7, 48'hA1A2A3A4A5A6, 32'hC0A80107, -1, 0, 0, 2, -1, 5, 0, -1);
    check("wr_req_len",  64'(req_hi_cnt), 64'd6);
    idle(1);

    // both acks together
    run_cmd(1, 9, 48'h112233445566, 32'h01020304, -1, 0, 0, 3, -1, 3, 2, -1);
    check("wr_same_len", 64'(req_hi_cnt), 64'd4);

    // lpm pulsed twice, cccp never: timeout
    run_cmd(1, 1, 48'hDEADBEEF0001, 32'h0BADF00D, -1, 0, 0, 1, 4, -1, 0, -1);
    check("wr_to_len",   64'(req_hi_cnt), 64'd255);
    idle(1);

    // read, no ack: timeout with zero data
    run_cmd(0, 4, 48'h0, 32'h0, -1, 48'hFFFFFFFFFFFF, 32'hFFFFFFFF, -1, -1, -1, 0, -1);
    check("rd_to_len",   64'(req_hi_cnt), 64'd255);

    // ack in the timeout cycle wins
    run_cmd(0, 6, 48'h0, 32'h0, TO - 1, 48'h123456789ABC, 32'h55AA55AA, -1, -1, -1, 0, -1);
    check("rd_last_len", 64'(req_hi_cnt), 64'd255);

    // out-of-range address, response held 10 cycles
    run_cmd(0, DEPTH, 48'h0, 32'h0, 0, 48'h1, 32'h1, -1, -1, -1, 10, -1);
    check("oor_req_len", 64'(req_hi_cnt), 64'd0);
    check("oor_latency", 64'(rsp_first_cyc - accept_cyc), 64'd1);

    // reset during WR_WAIT, then stale acks, then a clean read
    run_cmd(1, 5, 48'hCAFECAFECAFE, 32'h0A0A0A0A, -1, 0, 0, 1, -1, -1, 0, 3);
    check("rst_mid_len", 64'(req_hi_cnt), 64'd4);
    arp_wr_ack_lpm  = 1'b1;
    arp_wr_ack_cccp = 1'b1;
    set_idle_exp();
    step();
    clear_acks();
    run_cmd(0, 2, 48'h0, 32'h0, 1, 48'h0A0B0C0D0E0F, 32'hC0000002, -1, -1, -1, 0, -1);
    idle(2);

    // randomized commands
    for (int i = 0; i < 40; i++) begin
      r_wr   = 1'($urandom % 2);
      r_addr = $urandom_range(0, 27);
      r_mac  = 48'({$urandom, $urandom});
      r_ip   = $urandom;
      r_rmac = 48'({$urandom, $urandom});
      r_rip  = $urandom;
      r_sel  = $urandom % 16;
      r_a    = (r_sel == 0) ? -1 : (r_sel == 1) ? TO - 1 : $urandom_range(0, 6);
      r_l1   = $urandom_range(0, 6);
      r_l2   = ($urandom % 2) ? r_l1 + $urandom_range(1, 4) : -1;
      r_c    = (r_sel == 0) ? -1 : (r_sel == 1) ? TO - 1 : $urandom_range(0, 6);
      run_cmd(r_wr, r_addr, r_mac, r_ip, r_a, r_rmac, r_rip, r_l1, r_l2, r_c,
              $urandom_range(0, 3), -1);
      idle($urandom_range(0, 2));
    end

    idle(3);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
